// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer sitting directly in front of the data memory.
// It takes one core request at a time over a valid/ready handshake and
// drives the memory for that access. Byte loads come back sign- or
// zero-extended. Misaligned or out-of-range requests are answered with an
// error and never reach the memory.
//
// Ports
//   clk, reset         clock (rising edge), asynchronous active-low reset
//   req_*              core request: valid/ready, we, byte, signed, addr, wdata
//   resp_*             core response: valid/ready, data, err
//   mem_we/byte_src/a/wd, mem_rd
//                      memory interface (combinational read)
//
// Optional feature
//   MEM_ACCESS_COUNT_EN adds load_count/store_count/err_count (16-bit,
//   wrapping), each bumped when a response of that kind is consumed.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | memory inputs driven, waiting out WAIT_CYCLES then capturing
// RESP  | response held until the core takes it
module mem_access_unit #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ADDR_LIMIT  = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_we,
    output logic        mem_byte_src,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [15:0] load_count,
    output logic [15:0] store_count,
    output logic [15:0] err_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic        sgn_q, sgn_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_err;
    logic [31:0] ld_data;

    assign req_err = (!req_byte && (req_addr[1:0] != 2'b00)) || (req_addr >= ADDR_LIMIT);

    always_comb begin
        if (!byte_q) begin
            ld_data = mem_rd;
        end else if (sgn_q) begin
            ld_data = {{24{mem_rd[7]}}, mem_rd[7:0]};
        end else begin
            ld_data = {24'h0, mem_rd[7:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        byte_d  = byte_q;
        sgn_d   = sgn_q;
        a_d     = a_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    byte_d = req_byte;
                    sgn_d  = req_signed;
                    if (req_err) begin
                        // Memory address/data registers stay untouched so
                        // nothing on the memory side toggles for a bad request.
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = S_RESP;
                    end else begin
                        a_d = req_addr;
                        if (req_we) begin
                            wd_d = req_byte ? {24'h0, req_wdata[7:0]} : req_wdata;
                        end
                        err_d   = 1'b0;
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = we_q ? 32'h0 : ld_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            sgn_q   <= 1'b0;
            a_q     <= 32'h0;
            wd_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            sgn_q   <= sgn_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = (state_q == S_RESP);
    assign resp_data    = rdata_q;
    assign resp_err     = err_q;
    // Write strobe only on the last ISSUE cycle: one write edge per store.
    assign mem_we       = (state_q == S_ISSUE) && we_q && (cnt_q == 4'd0);
    assign mem_byte_src = (state_q == S_ISSUE) && byte_q;
    assign mem_a        = a_q;
    assign mem_wd       = wd_q;

`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] ld_cnt_q, st_cnt_q, er_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_cnt_q <= 16'h0;
            st_cnt_q <= 16'h0;
            er_cnt_q <= 16'h0;
        end else if ((state_q == S_RESP) && resp_ready) begin
            if (err_q) begin
                er_cnt_q <= er_cnt_q + 16'd1;
            end else if (we_q) begin
                st_cnt_q <= st_cnt_q + 16'd1;
            end else begin
                ld_cnt_q <= ld_cnt_q + 16'd1;
            end
        end
    end

    assign load_count  = ld_cnt_q;
    assign store_count = st_cnt_q;
    assign err_count   = er_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n        [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic        req_byte     [2];
    logic        req_signed   [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic        resp_ready   [2];
    logic [31:0] resp_data    [2];
    logic        resp_err     [2];
    logic        mem_we       [2];
    logic        mem_byte_src [2];
    logic [31:0] mem_a        [2];
    logic [31:0] mem_wd       [2];
    logic [31:0] mem_rd       [2];
`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] load_count   [2];
    logic [15:0] store_count  [2];
    logic [15:0] err_count    [2];
`endif

    // Instance 0 runs with WAIT_CYCLES = 0, instance 1 with WAIT_CYCLES = 3.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_unit #(.WAIT_CYCLES(g == 0 ? 0 : 3)) u_dut (
            .clk         (clk),
            .reset       (rst_n[g]),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_we      (req_we[g]),
            .req_byte    (req_byte[g]),
            .req_signed  (req_signed[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .resp_valid  (resp_valid[g]),
            .resp_ready  (resp_ready[g]),
            .resp_data   (resp_data[g]),
            .resp_err    (resp_err[g]),
            .mem_we      (mem_we[g]),
            .mem_byte_src(mem_byte_src[g]),
            .mem_a       (mem_a[g]),
            .mem_wd      (mem_wd[g]),
            .mem_rd      (mem_rd[g])
`ifdef MEM_ACCESS_COUNT_EN
            ,
            .load_count  (load_count[g]),
            .store_count (store_count[g]),
            .err_count   (err_count[g])
`endif
        );
    end

    initial forever #5 clk = ~clk;

    // Memory models (one per instance), plus edge monitors.
    bit   [7:0]  mem_m [2][1024];
    bit   [7:0]  ref_m [2][1024];
    int          we_cnt [2];
    int          bs_cnt [2];
    logic [31:0] we_wd  [2];
    logic [31:0] we_a   [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_we[k] === 1'b1) begin
                we_cnt[k]++;
                we_wd[k] = mem_wd[k];
                we_a[k]  = mem_a[k];
                if (mem_byte_src[k]) begin
                    mem_m[k][mem_a[k][9:0]] = mem_wd[k][7:0];
                end else begin
                    for (int b = 0; b < 4; b++) mem_m[k][{mem_a[k][9:2], 2'(b)}] = mem_wd[k][8*b +: 8];
                end
            end
            if (mem_byte_src[k] === 1'b1) bs_cnt[k]++;
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            if (mem_byte_src[k]) begin
                mem_rd[k] = {24'h0, mem_m[k][mem_a[k][9:0]]};
            end else begin
                mem_rd[k] = {mem_m[k][{mem_a[k][9:2], 2'd3}], mem_m[k][{mem_a[k][9:2], 2'd2}],
                             mem_m[k][{mem_a[k][9:2], 2'd1}], mem_m[k][{mem_a[k][9:2], 2'd0}]};
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int exp_ld [2];
    int exp_st [2];
    int exp_er [2];

    function automatic int wc(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-array memory, little-endian, limit 0x400.
    task automatic ref_txn(input int d, input bit we, input bit byt, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output bit err, output logic [31:0] data);
        int ix;
        err  = (!byt && (addr % 4 != 0)) || (addr >= 32'h400);
        data = 32'h0;
        if (!err) begin
            ix = int'(addr);
            if (we) begin
                if (byt) ref_m[d][ix] = wdata[7:0];
                else for (int b = 0; b < 4; b++) ref_m[d][ix + b] = 8'(wdata >> (8 * b));
            end else if (byt) begin
                data = 32'(ref_m[d][ix]);
                if (sgn && data >= 32'h80) data = data - 32'h100;
            end else begin
                for (int b = 0; b < 4; b++) data = data + (32'(ref_m[d][ix + b]) << (8 * b));
            end
        end
    endtask

    task automatic txn(input int d, input bit we, input bit byt, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, input bit intrude, input string tag,
                       output bit got_err, output logic [31:0] got_data);
        bit          e_err;
        logic [31:0] e_data;
        int          lat, we0, bs0, guard;
        ref_txn(d, we, byt, sgn, addr, wdata, e_err, e_data);
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk({tag, " req_ready idle"}, 32'(req_ready[d]), 32'd1);
        we0 = we_cnt[d];
        bs0 = bs_cnt[d];
        req_we[d] = we; req_byte[d] = byt; req_signed[d] = sgn;
        req_addr[d] = addr; req_wdata[d] = wdata; req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (resp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        got_err  = resp_err[d];
        got_data = resp_data[d];
        chk({tag, " latency"}, 32'(lat), e_err ? 32'd1 : 32'(2 + wc(d)));
        chk({tag, " resp_err"}, 32'(resp_err[d]), 32'(e_err));
        chk({tag, " resp_data"}, resp_data[d], e_data);
        chk({tag, " byte_src cycles"}, 32'(bs_cnt[d] - bs0), (byt && !e_err) ? 32'(1 + wc(d)) : 32'd0);
        if (we && !e_err) begin
            chk({tag, " mem_wd"}, we_wd[d], byt ? {24'h0, wdata[7:0]} : wdata);
            chk({tag, " mem_a"}, we_a[d], addr);
        end
        for (int h = 0; h < hold; h++) begin
            if (intrude) begin
                req_we[d] = 1'b1; req_byte[d] = 1'b0; req_addr[d] = 32'h10;
                req_wdata[d] = 32'hA5A5_5A5A; req_valid[d] = 1'b1;
            end
            @(posedge clk); #1;
            chk({tag, " hold valid/ready"}, {30'h0, resp_valid[d], req_ready[d]}, 32'd2);
            chk({tag, " hold data"}, resp_data[d], e_data);
            chk({tag, " hold err"}, 32'(resp_err[d]), 32'(e_err));
        end
        req_valid[d] = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        if (e_err) exp_er[d]++;
        else if (we) exp_st[d]++;
        else exp_ld[d]++;
        chk({tag, " back to idle"}, {30'h0, resp_valid[d], req_ready[d]}, 32'd1);
        chk({tag, " write edges"}, 32'(we_cnt[d] - we0), (we && !e_err) ? 32'd1 : 32'd0);
    endtask

    typedef struct {
        bit          we, byt, sgn;
        logic [31:0] addr, wdata;
        bit          exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vt [15];
    bit          g_err;
    logic [31:0] g_data;
    int          we0;

    initial begin
        vt[0]  = '{1, 0, 0, 32'h0000_0000, 32'h8344_22F1, 0, 32'h0};
        vt[1]  = '{0, 1, 1, 32'h0000_0003, 32'h0,         0, 32'hFFFF_FF83};
        vt[2]  = '{0, 1, 0, 32'h0000_0003, 32'h0,         0, 32'h0000_0083};
        vt[3]  = '{1, 0, 0, 32'h0000_0008, 32'hDEAD_BEEF, 0, 32'h0};
        vt[4]  = '{0, 0, 0, 32'h0000_0008, 32'h0,         0, 32'hDEAD_BEEF};
        vt[5]  = '{0, 0, 0, 32'h0000_0002, 32'h0,         1, 32'h0};
        vt[6]  = '{0, 0, 0, 32'h0000_0400, 32'h0,         1, 32'h0};
        vt[7]  = '{0, 1, 0, 32'h0000_03FF, 32'h0,         0, 32'h0};
        vt[8]  = '{1, 0, 0, 32'h0000_03FC, 32'h1122_3344, 0, 32'h0};
        vt[9]  = '{0, 1, 1, 32'h0000_03FD, 32'h0,         0, 32'h0000_0033};
        vt[10] = '{0, 1, 0, 32'hFFFF_FFFF, 32'h0,         1, 32'h0};
        vt[11] = '{1, 1, 0, 32'h0000_0001, 32'hFFFF_FF55, 0, 32'h0};
        vt[12] = '{0, 0, 0, 32'h0000_0000, 32'h0,         0, 32'h8344_55F1};
        vt[13] = '{1, 0, 0, 32'h0000_0006, 32'h1234_5678, 1, 32'h0};
        vt[14] = '{0, 0, 0, 32'h0000_0004, 32'h0,         0, 32'h0};

        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_byte[k] = 1'b0;
            req_signed[k] = 1'b0; req_addr[k] = 32'h0; req_wdata[k] = 32'h0; resp_ready[k] = 1'b0;
            exp_ld[k] = 0; exp_st[k] = 0; exp_er[k] = 0;
        end
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset ready/valid/err", {29'h0, req_ready[k], resp_valid[k], resp_err[k]}, 32'd4);
            chk("reset resp_data", resp_data[k], 32'h0);
            chk("reset mem_we/byte_src", {30'h0, mem_we[k], mem_byte_src[k]}, 32'd0);
            chk("reset mem_a", mem_a[k], 32'h0);
            chk("reset mem_wd", mem_wd[k], 32'h0);
            rst_n[k] = 1'b1;
        end
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            txn(0, vt[i].we, vt[i].byt, vt[i].sgn, vt[i].addr, vt[i].wdata, 0, 0, $sformatf("vec%0d", i), g_err, g_data);
            chk($sformatf("vec%0d table err", i), 32'(g_err), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d table data", i), g_data, vt[i].exp_data);
        end

        // Backpressure with an intruding request that must be ignored.
        txn(0, 0, 0, 0, 32'h8, 32'h0, 3, 1, "hold", g_err, g_data);
        txn(0, 0, 0, 0, 32'h10, 32'h0, 0, 0, "after-hold", g_err, g_data);
        chk("after-hold no intruder write", g_data, 32'h0);

        // WAIT_CYCLES = 3 byte store, then an aborted repeat.
        txn(1, 1, 1, 0, 32'h5, 32'h1234_56AB, 0, 0, "w3 bstore", g_err, g_data);
        we0 = we_cnt[1];
        req_we[1] = 1'b1; req_byte[1] = 1'b1; req_signed[1] = 1'b0;
        req_addr[1] = 32'h5; req_wdata[1] = 32'h0000_00CD; req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("abort c1 we/bsrc", {30'h0, mem_we[1], mem_byte_src[1]}, 32'd1);
        chk("abort c1 mem_wd", mem_wd[1], 32'h0000_00CD);
        @(posedge clk); #1;
        chk("abort c2 we", 32'(mem_we[1]), 32'd0);
        rst_n[1] = 1'b0;
        #1;
        chk("abort rst we/ready/valid", {29'h0, mem_we[1], req_ready[1], resp_valid[1]}, 32'd2);
        exp_ld[1] = 0; exp_st[1] = 0; exp_er[1] = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n[1] = 1'b1;
        chk("abort no write edge", 32'(we_cnt[1] - we0), 32'd0);
        chk("abort mem byte", 32'(mem_m[1][5]), 32'hAB);
        @(posedge clk); #1;
        txn(1, 0, 1, 0, 32'h5, 32'h0, 0, 0, "w3 reload", g_err, g_data);
        chk("w3 reload value", g_data, 32'h0000_00AB);

        for (int i = 0; i < 200; i++) begin
            int          d, r;
            bit          we, byt, sgn;
            logic [31:0] addr;
            d   = $urandom_range(0, 1);
            we  = 1'($urandom_range(0, 1));
            byt = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            if (r == 0) addr = $urandom;
            else if (r == 1) addr = 32'h3F8 + 32'($urandom_range(0, 15));
            else begin
                addr = 32'($urandom_range(0, 1023));
                if (!byt && r < 8) addr = addr & ~32'h3;
            end
            txn(d, we, byt, sgn, addr, $urandom, $urandom_range(0, 2), 0, $sformatf("rnd%0d", i), g_err, g_data);
        end

`ifdef MEM_ACCESS_COUNT_EN
        for (int k = 0; k < 2; k++) begin
            chk("load_count", 32'(load_count[k]), 32'(exp_ld[k] % 65536));
            chk("store_count", 32'(store_count[k]), 32'(exp_st[k] % 65536));
            chk("err_count", 32'(err_count[k]), 32'(exp_er[k] % 65536));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
